// File: rtl/mips_pkg.sv
// mips_pkg: opcode map, op_class codes and encoder FSM states shared by the encoder and the control decoder.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [2:0] CL_R   = 3'd0;
  localparam logic [2:0] CL_LW  = 3'd1;
  localparam logic [2:0] CL_SW  = 3'd2;
  localparam logic [2:0] CL_BEQ = 3'd3;
  localparam logic [2:0] CL_BNE = 3'd4;
  localparam logic [2:0] CL_J   = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: session control, decoded-field stream and instruction-memory write bus of the encoder.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_class;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              err;
  logic              busy;
  modport master (
    output start, base_addr, finish, in_valid, op_class, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_cnt, err, busy
  );
  modport slave (
    input  start, base_addr, finish, in_valid, op_class, rs, rt, rd, shamt, funct, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata, word_cnt, err, busy
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field-to-word packer with illegal-class flag.
// Macro INSTR_ENC_BNE_EN makes op_class 4 encode BNE; otherwise it is illegal.
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  i_op_class,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_op_class)
      CL_R:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
      CL_LW:  o_word = {OP_LW, i_rs, i_rt, i_imm};
      CL_SW:  o_word = {OP_SW, i_rs, i_rt, i_imm};
      CL_BEQ: o_word = {OP_BEQ, i_rs, i_rt, i_imm};
`ifdef INSTR_ENC_BNE_EN
      CL_BNE: o_word = {OP_BNE, i_rs, i_rt, i_imm};
`endif
      CL_J:   o_word = {OP_J, i_target};
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: session FSM, write pointer, word counter and registered imem write port.
// BNE support follows macro INSTR_ENC_BNE_EN (see instr_pack).
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [31:0]       r_wdata, w_word;
  logic              r_we, r_err, w_illegal, w_accept, w_write, w_last;
  instr_pack u_pack (
    .i_op_class(bus.op_class),
    .i_rs      (bus.rs),
    .i_rt      (bus.rt),
    .i_rd      (bus.rd),
    .i_shamt   (bus.shamt),
    .i_funct   (bus.funct),
    .i_imm     (bus.imm),
    .i_target  (bus.target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );
  // finish outranks a beat presented in the same cycle
  always_comb begin
    w_accept = (r_state == S_RUN) && !bus.finish && bus.in_valid;
    w_write  = w_accept && !w_illegal;
    w_last   = w_write && (r_cnt == LAST);
    w_next   = (r_state == S_IDLE) ? (bus.start ? S_RUN : S_IDLE) :
               bus.finish ? S_IDLE : w_last ? S_FULL : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we  <= w_write;
      r_err <= w_accept && w_illegal;
      if (r_state == S_IDLE && bus.start) begin
        r_ptr <= bus.base_addr;
        r_cnt <= '0;
      end else if (w_write) begin
        r_ptr <= r_ptr + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_write) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
      end
    end
  end
  assign bus.in_ready   = (r_state == S_RUN);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.word_cnt   = r_cnt;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder (DEPTH=4) against a session-level reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
`ifdef INSTR_ENC_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  bit m_open = 0;
  bit m_full = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder #(.ADDR_W(8), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic bit legal(int c);
    return c <= 3 || c == 5 || (c == 4 && BNE_ON);
  endfunction

  function automatic logic [31:0] ref_word();
    longint op_unit = 67108864;
    longint regs = longint'(bus.rs) * 2097152 + longint'(bus.rt) * 65536;
    longint r;
    case (int'(bus.op_class))
      0: r = regs + longint'(bus.rd) * 2048 + longint'(bus.shamt) * 64 + longint'(bus.funct);
      1: r = 35 * op_unit + regs + longint'(bus.imm);
      2: r = 43 * op_unit + regs + longint'(bus.imm);
      3: r = 4 * op_unit + regs + longint'(bus.imm);
      4: r = 5 * op_unit + regs + longint'(bus.imm);
      default: r = 2 * op_unit + longint'(bus.target);
    endcase
    return r[31:0];
  endfunction

  task automatic step();
    logic exp_we, exp_err;
    logic [31:0] exp_w;
    int exp_a;
    @(posedge clk);
    #1;
    exp_we = 0; exp_err = 0; exp_w = 0; exp_a = 0;
    if (!m_open) begin
      if (bus.start) begin m_open = 1; m_full = 0; m_ptr = int'(bus.base_addr); m_cnt = 0; end
    end else if (bus.finish) m_open = 0;
    else if (!m_full && bus.in_valid) begin
      if (legal(int'(bus.op_class))) begin
        exp_we = 1; exp_a = m_ptr; exp_w = ref_word();
        m_ptr = (m_ptr + 1) % 256;
        m_cnt++;
        m_full = (m_cnt == DEPTH);
      end else exp_err = 1;
    end
    check("we", 32'(bus.imem_we), 32'(exp_we));
    check("err", 32'(bus.err), 32'(exp_err));
    if (exp_we) begin
      check("addr", 32'(bus.imem_addr), 32'(exp_a));
      check("wdata", bus.imem_wdata, exp_w);
    end
    check("cnt", 32'(bus.word_cnt), 32'(m_cnt));
    check("busy", 32'(bus.busy), 32'(m_open));
    check("ready", 32'(bus.in_ready), 32'(m_open && !m_full));
  endtask

  task automatic open_s(logic [7:0] base);
    bus.in_valid = 0; bus.finish = 0; bus.start = 1; bus.base_addr = base;
    step();
    bus.start = 0;
  endtask

  task automatic close_s();
    bus.in_valid = 0; bus.finish = 1;
    step();
    bus.finish = 0;
  endtask

  task automatic beat(int c, int rs, int rt, int rd, int sh, int fn, int im, int tg);
    bus.op_class = 3'(c); bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd);
    bus.shamt = 5'(sh); bus.funct = 6'(fn); bus.imm = 16'(im); bus.target = 26'(tg);
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
  endtask

  task automatic rand_fields();
    bus.op_class = 3'($urandom_range(0, 7));
    bus.rs = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom);
    bus.shamt = 5'($urandom); bus.funct = 6'($urandom);
    bus.imm = 16'($urandom); bus.target = 26'($urandom);
  endtask

  initial begin
    bus.start = 0; bus.finish = 0; bus.in_valid = 0; bus.base_addr = 0;
    rand_fields();
    #3;
    check("rst_we", 32'(bus.imem_we), 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_cnt", 32'(bus.word_cnt), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ready", 32'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();
    // first R beat and back-to-back loads/stores/jump
    open_s(8'h10);
    beat(0, 1, 2, 3, 0, 'h20, 0, 0);
    check("r_wdata", bus.imem_wdata, 32'h00221820);
    check("r_addr", 32'(bus.imem_addr), 32'h10);
    check("r_cnt", 32'(bus.word_cnt), 1);
    beat(1, 4, 5, 0, 0, 0, 'h0008, 0);
    check("lw_wdata", bus.imem_wdata, 32'h8C850008);
    beat(2, 4, 5, 0, 0, 0, 'h0008, 0);
    check("sw_wdata", bus.imem_wdata, 32'hAC850008);
    beat(5, 0, 0, 0, 0, 0, 0, 'h40);
    check("j_wdata", bus.imem_wdata, 32'h08000040);
    check("j_addr", 32'(bus.imem_addr), 32'h13);
    close_s();
    // illegal class between two legal beats
    open_s(8'h20);
    beat(0, 1, 2, 3, 0, 'h20, 0, 0);
    beat(7, 1, 2, 3, 0, 'h20, 0, 0);
    check("ill_err", 32'(bus.err), 1);
    check("ill_we", 32'(bus.imem_we), 0);
    beat(1, 4, 5, 0, 0, 0, 'h0008, 0);
    check("ill_next_addr", 32'(bus.imem_addr), 32'h21);
    close_s();
    // pointer wrap and FULL
    open_s(8'hFE);
    for (int i = 0; i < 5; i++) begin
      beat(0, i, i + 1, i + 2, 0, 'h20, 0, 0);
      if (i == 3) check("full_ready", 32'(bus.in_ready), 0);
      if (i == 4) check("full_no_we", 32'(bus.imem_we), 0);
    end
    check("full_cnt", 32'(bus.word_cnt), 4);
    close_s();
    check("full_idle", 32'(bus.busy), 0);
    // branches
    open_s(8'h30);
    beat(3, 1, 2, 0, 0, 0, 'hFFFF, 0);
    check("beq_wdata", bus.imem_wdata, 32'h1022FFFF);
    beat(4, 1, 2, 0, 0, 0, 'hFFFF, 0);
`ifdef INSTR_ENC_BNE_EN
    check("bne_wdata", bus.imem_wdata, 32'h1422FFFF);
`else
    check("bne_err", 32'(bus.err), 1);
    check("bne_no_we", 32'(bus.imem_we), 0);
`endif
    close_s();
    // randomized sessions
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 11) == 0);
      bus.finish = ($urandom_range(0, 19) == 0);
      bus.base_addr = 8'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      rand_fields();
      step();
    end
    bus.start = 0; bus.finish = 0; bus.in_valid = 0;
    // asynchronous reset with a write in flight
    if (m_open) close_s();
    open_s(8'h40);
    bus.op_class = 3'd0; bus.in_valid = 1;
    @(posedge clk);
    #1;
    check("inflight_we", 32'(bus.imem_we), 1);
    rst_n = 0;
    #1;
    check("arst_we", 32'(bus.imem_we), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_cnt", 32'(bus.word_cnt), 0);
    check("arst_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_open = 0; m_full = 0; m_cnt = 0; m_ptr = 0;
    repeat (3) step();
    bus.in_valid = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader. It is the write-side counterpart of the main control decoder: it accepts decoded instruction fields over a valid/ready stream and packs each into a 32-bit MIPS word using the same opcode map the decoder consumes. It writes the words into consecutive instruction-memory addresses starting from a programmed base, and is used by the boot/test path to fill instruction memory before the core is released.

## Interface
Parameters:
- ADDR_W, 8: word-address width of instruction memory.
- DEPTH, 256: number of words writable per load session (≤ 2^ADDR_W).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that opens a load session; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address, sampled on start.
- finish  in  1  closes the session; returns to IDLE from RUN or FULL.
- in_valid  in  1  field beat valid.
- in_ready  out  1  encoder accepts a beat this cycle.
- op_class  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=BNE, 5=J, 6–7 illegal.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  R-type function.
- imm  in  16  I-type immediate.
- target  in  26  J-type target.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- word_cnt  out  ADDR_W+1  words written this session.
- err  out  1  one-cycle pulse on an accepted illegal beat.
- busy  out  1  high in RUN or FULL.

Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.

## Operation
- FSM states: IDLE, RUN, FULL. Reset state is IDLE.
- IDLE → RUN on start. The write pointer is loaded from base_addr and word_cnt is cleared.
- RUN: in_ready=1. A beat is accepted when in_valid && in_ready. It is encoded as follows:
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2b, rs, rt, imm}.
  - BEQ: {6'h04, rs, rt, imm}.
  - BNE: {6'h05, rs, rt, imm}. Only when the macro is defined; see Configuration.
  - J: {6'h02, target}.
- Illegal op_class is accepted but not written: err pulses, and the pointer and word_cnt are unchanged.
- Each legal beat increments the pointer (mod 2^ADDR_W; it wraps silently) and word_cnt.
- RUN → FULL when word_cnt reaches DEPTH. This happens in the same cycle as the DEPTH-th write is registered.
- FULL: in_ready=0 and no writes.
- finish in RUN or FULL → IDLE. finish takes priority over a beat presented in the same cycle; that beat is not accepted.
- start is ignored outside IDLE. start and finish together in IDLE: start wins.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, word_cnt=0, err=0, busy=0, in_ready=0.

## Timing
- Beat accepted at edge N → imem_we=1 with its addr/wdata during cycle N+1. Latency is 1 cycle.
- Throughput is 1 word per cycle. The encoder applies no back-pressure from memory; imem accepts every write.
- in_ready is a registered function of the state only. It drops the cycle after the DEPTH-th acceptance.
- err is asserted in cycle N+1, aligned with where imem_we would have been.
- Asynchronous reset mid-session: all outputs go to their reset values immediately. An in-flight write is dropped.

## Configuration
- INSTR_ENC_BNE_EN defined: op_class 4 encodes BNE with opcode 6'h05.
- Undefined: op_class 4 is illegal. It raises err and no word is written.

## Structure
- Shared package mips_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J.
  - The op_class encoding constants.
  - The FSM state constants.
- The decoder uses the same opcode constants.
- One sub-module, instr_pack: a combinational field-to-word packer that also outputs an illegal flag. The top level holds the FSM, pointer, counter and output register.

## Test plan
- Reset, start with base_addr=0x10, one R beat (rs=1, rt=2, rd=3, shamt=0, funct=0x20) → cycle N+1: imem_we=1, addr=0x10, wdata=0x00221820, word_cnt=1.
- Back-to-back LW (rs=4, rt=5, imm=0x0008), SW (same fields), J (target=0x0000040) → wdata 0x8C850008, 0xAC850008, 0x08000040 at consecutive addresses with no gaps.
- op_class=7 between two legal beats → err pulse, no write; the next legal word lands at the next sequential address.
- DEPTH=4, base=0xFE, 5 valid beats → writes at 0xFE, 0xFF, 0x00, 0x01; in_ready low after the 4th; FULL; the 5th beat is not accepted. finish → IDLE.
- BEQ and BNE with rs=1, rt=2, imm=0xFFFF → 0x1022FFFF; with the macro, 0x1422FFFF; without it, err and no write.
- rst_n low while in RUN with a beat in flight → imem_we=0 and busy=0 immediately. After release the encoder is in IDLE and ignores in_valid until start.
